// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings
// (the PLL's RST/LOCK pins, the restart request and the status outputs).
//   pll_locked  PLL LOCK output, asynchronous to the supervisor clock
//   req_reset   synchronous request to restart the PLL (level or pulse)
//   pll_rst     PLL RST pin, active high
//   sys_rst_n   active-low reset for the downstream pixel/TMDS logic
//   state       supervisor state: 0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN
//   lost_cnt    lock losses detected in RUN, saturating at 255
//   fail        sticky: too many consecutive lock attempts timed out
// master: the supervisor.  slave: the PLL / system side.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [1:0] state;
    logic [7:0] lost_cnt;
    logic       fail;

    modport master (
        input  pll_locked,
        input  req_reset,
        output pll_rst,
        output sys_rst_n,
        output state,
        output lost_cnt,
        output fail
    );

    modport slave (
        output pll_locked,
        output req_reset,
        input  pll_rst,
        input  sys_rst_n,
        input  state,
        input  lost_cnt,
        input  fail
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor for the 25->250 MHz HDMI PLL, clocked by the 25 MHz
// reference. Pulses the PLL RST pin, qualifies the synchronised LOCK signal
// and only releases the downstream system reset after lock has been stable.
// Lock loss in RUN re-resets the PLL; lock attempts that time out are retried
// and counted, and fail latches once too many consecutive attempts failed.
// Ports:
//   in_clk25  25 MHz reference clock, the only clock of this block
//   rst_n     asynchronous active-low reset
//   bus       pll_lock_supervisor_if.master (pll_locked, req_reset in;
//             pll_rst, sys_rst_n, state, lost_cnt, fail out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst high for RST_CYCLES cycles
// WAIT_LOCK | pll_rst low, wait up to LOCK_TIMEOUT cycles for locked_s
// STABILIZE | locked_s must stay high for STABLE_CYCLES consecutive cycles
// RUN       | sys_rst_n released; GLITCH_CYCLES low cycles count as loss
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int MAX_RETRIES   = 8
) (
    input  logic                     in_clk25,
    input  logic                     rst_n,
    pll_lock_supervisor_if.master    bus
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int GL_W  = $clog2(GLITCH_CYCLES + 1);
    localparam int RT_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GL_W-1:0]  GL_LAST   = GL_W'(GLITCH_CYCLES - 1);
    localparam logic [RT_W-1:0]  RT_MAX    = RT_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [GL_W-1:0]   glitch_q, glitch_nxt;
    logic [RT_W-1:0]   retries_q, retries_nxt;
    logic [7:0]        lost_q, lost_nxt;
    logic              fail_q, fail_nxt;
    logic              pll_rst_q;
    logic              sys_rst_n_q;
    logic              sync_ff;
    logic              locked_s;

    // Priority: req_reset, then timeout / lock loss, then lock detect.
    always_comb begin
        state_nxt   = state_q;
        retries_nxt = retries_q;
        lost_nxt    = lost_q;
        fail_nxt    = fail_q;
        glitch_nxt  = '0;
        if (bus.req_reset) begin
            state_nxt = RESET_PLL;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (cnt_q == TO_LAST) begin
                        state_nxt = RESET_PLL;
                        if (retries_q != RT_MAX) retries_nxt = retries_q + 1'b1;
                        if (retries_nxt == RT_MAX) fail_nxt = 1'b1;
                    end else if (locked_s) begin
                        state_nxt = STABILIZE;
                    end
                end
                STABILIZE: begin
                    // A dropout only restarts the lock wait; the PLL itself
                    // is not reset again.
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt_q == STAB_LAST) begin
                        state_nxt   = RUN;
                        retries_nxt = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        if (glitch_q == GL_LAST) begin
                            state_nxt = RESET_PLL;
                            if (lost_q != 8'hFF) lost_nxt = lost_q + 8'd1;
                        end else begin
                            glitch_nxt = glitch_q + 1'b1;
                        end
                    end
                end
                default: state_nxt = RESET_PLL;
            endcase
        end
    end

    always_ff @(posedge in_clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            glitch_q    <= '0;
            retries_q   <= '0;
            lost_q      <= '0;
            fail_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            sync_ff     <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            sync_ff   <= bus.pll_locked;
            locked_s  <= sync_ff;
            state_q   <= state_nxt;
            // The timer restarts on every state change and is held at zero
            // while req_reset is asserted; it is unused in RUN.
            if (state_nxt != state_q || bus.req_reset || state_q == RUN)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            glitch_q    <= glitch_nxt;
            retries_q   <= retries_nxt;
            lost_q      <= lost_nxt;
            fail_q      <= fail_nxt;
            pll_rst_q   <= (state_nxt == RESET_PLL);
            sys_rst_n_q <= (state_nxt == RUN);
        end
    end

    assign bus.state     = state_q;
    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.lost_cnt  = lost_q;
    assign bus.fail      = fail_q;

endmodule
